trng_sample_ctrl: RTL and testbench
===================================

TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 64: number of clock cycles raw bits are discarded after enable.
REQ-002 SHALL have parameter RCT_CUTOFF, default 16: run length of identical raw bits that trips the repetition-count health test; legal range 2..255.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of 32-bit output words buffered; power of two.
REQ-004 S_AXI_ACLK  in  1  sole clock.
REQ-005 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 ctrl_enable  in  1  level from control register bit 0; run the entropy source.
REQ-007 ctrl_clear  in  1  single-cycle pulse; flush FIFO, partial word and fault.
REQ-008 raw_bit  in  1  entropy sample, already synchronised to S_AXI_ACLK.
REQ-009 raw_valid  in  1  qualifies raw_bit for one cycle.
REQ-010 rd_req  in  1  single-cycle pulse from the AXI read of the data register; pops the FIFO head.
REQ-011 osc_en  out  1  enables the ring-oscillator source.
REQ-012 rd_data  out  32  FIFO head word; 0 when FIFO is empty.
REQ-013 data_avail  out  1  FIFO non-empty.
REQ-014 fifo_count  out  clog2(FIFO_DEPTH)+1  words held.
REQ-015 health_fail  out  1  sticky health-test failure.
REQ-016 state  out  2  current FSM state encoding, for the status register.

Function
REQ-017 FSM states SHALL be IDLE=0, WARMUP=1, COLLECT=2, FAULT=3.
REQ-018 IDLE: osc_en=0; ctrl_enable=1 -> WARMUP, warm-up counter cleared.
REQ-019 WARMUP: osc_en=1; raw bits ignored; after exactly WARMUP_CYCLES cycles in WARMUP -> COLLECT.
REQ-020 COLLECT: osc_en=1; on raw_valid, word register shifts left with raw_bit entering bit 0, and the bit counter increments.
REQ-021 On the 32nd accepted bit, the completed word SHALL be pushed, and data_avail SHALL be high on the next cycle (1-cycle latency); the bit counter wraps to 0.
REQ-022 When the FIFO is full and a word completes, the word SHALL be held and further raw_valid ignored until a pop frees a slot; push occurs in the pop cycle.
REQ-023 Repetition-count test SHALL run on every accepted bit in COLLECT; reaching RCT_CUTOFF consecutive identical bits -> FAULT next cycle, health_fail=1, and the partial word is discarded.
REQ-024 FAULT: osc_en=0; no pushes; the FIFO stays readable; exited only by ctrl_clear -> IDLE.
REQ-025 ctrl_enable=0 in WARMUP or COLLECT SHALL return to IDLE next cycle, discarding the partial word and the RCT run while retaining the FIFO.
REQ-026 ctrl_clear in any state SHALL empty the FIFO, clear the partial word, the RCT run and health_fail, and go to IDLE; it takes priority over every simultaneous event, including push, pop and enable.
REQ-027 rd_req on an empty FIFO SHALL be ignored; simultaneous push and pop on a full FIFO SHALL leave fifo_count unchanged.
REQ-028 rd_data SHALL be combinational from the FIFO head, so the popped value is valid in the rd_req cycle.

Reset
REQ-029 Reset SHALL force: state=IDLE, osc_en=0, rd_data=0, data_avail=0, fifo_count=0, health_fail=0, and all counters and the word register to 0.
REQ-030 A reset asserted mid-word or in FAULT SHALL leave no residual partial data after release.

Structure
REQ-031 The state enum, the 32-bit word width constant and the state encodings SHALL live in package trng_pkg, shared with the AXI-lite register block.
REQ-032 The output buffer SHALL be one sub-module, trng_word_fifo (synchronous FIFO, same clock/reset); the FSM, shifter and health test stay in trng_sample_ctrl.

Verification
REQ-033 Enable, WARMUP_CYCLES=64, feed alternating 1,0 starting with 1, 32 valid bits -> osc_en=1 from the cycle after enable; rd_data=0xAAAAAAAA; data_avail high one cycle after the 32nd bit.
REQ-034 Feed 16 consecutive 1s in COLLECT -> state=FAULT, health_fail=1, osc_en=0, fifo_count unchanged; ctrl_clear -> IDLE, health_fail=0, fifo_count=0.
REQ-035 Fill 4 words without reading, then send 32 more bits -> fifo_count=4, 5th word held; one rd_req -> first word popped, 5th word pushed in the same cycle, count stays 4.
REQ-036 Drop ctrl_enable after 20 bits -> IDLE next cycle; re-enable and pass warm-up, then 32 bits of pattern 0xAAAAAAAA -> exactly 0xAAAAAAAA, no stale bits.
REQ-037 Assert reset mid-word and in FAULT -> all outputs at reset values; rd_req on empty -> fifo_count stays 0, rd_data=0.
REQ-038 ctrl_clear coincident with a 32nd bit and an rd_req -> fifo_count=0, state=IDLE, no word pushed.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sampler and its AXI-lite register block.
package trng_pkg;

   localparam int unsigned WORD_W = 32;

   // Encodings are visible in the status register.
   typedef enum logic [1:0] {
      TRNG_IDLE    = 2'd0,
      TRNG_WARMUP  = 2'd1,
      TRNG_COLLECT = 2'd2,
      TRNG_FAULT   = 2'd3
   } trng_state_e;

endpackage : trng_pkg

// File: rtl/trng_sample_ctrl_if.sv
// Control, entropy-input and readout signals of the TRNG sampler.
interface trng_sample_ctrl_if #(
   parameter int unsigned FIFO_DEPTH = 4
) ();
   import trng_pkg::*;

   logic                          ctrl_enable;
   logic                          ctrl_clear;
   logic                          raw_bit;
   logic                          raw_valid;
   logic                          rd_req;
   logic                          osc_en;
   logic [WORD_W-1:0]             rd_data;
   logic                          data_avail;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          health_fail;
   logic [1:0]                    state;

   modport master (
      output ctrl_enable, ctrl_clear, raw_bit, raw_valid, rd_req,
      input  osc_en, rd_data, data_avail, fifo_count, health_fail, state
   );

   modport slave (
      input  ctrl_enable, ctrl_clear, raw_bit, raw_valid, rd_req,
      output osc_en, rd_data, data_avail, fifo_count, health_fail, state
   );

endinterface : trng_sample_ctrl_if

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO buffering completed entropy words for readout.
// Head is combinational and reads as zero when empty.
module trng_word_fifo
   import trng_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    push,
   input  logic [WORD_W-1:0]       push_data,
   input  logic                    pop,
   output logic [WORD_W-1:0]       head,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];
   // A pop in the same cycle frees the slot a push on a full FIFO needs.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Next-state for storage, pointers and occupancy; clear wins over everything.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : trng_word_fifo

// File: rtl/trng_sample_ctrl.sv
// TRNG sampling controller: warm-up, 32-bit word assembly, repetition-count
// health test and buffered readout of completed words.
module trng_sample_ctrl
   import trng_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES = 64,
   parameter int unsigned RCT_CUTOFF    = 16,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic               S_AXI_ACLK,
   input  logic               S_AXI_ARESETN,
   trng_sample_ctrl_if.slave  bus
);

   localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
   localparam int unsigned BW = $clog2(WORD_W);

   trng_state_e       state_q, state_d;
   logic [WW-1:0]     warm_cnt_q, warm_cnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              pending_q, pending_d;
   logic              last_bit_q, last_bit_d;
   logic [7:0]        run_cnt_q, run_cnt_d;
   logic              health_fail_q, health_fail_d;

   logic              fifo_push;
   logic [WORD_W-1:0] push_word;
   logic              fifo_full, fifo_empty;
   logic              can_accept;
   logic [WORD_W-1:0] shifted;
   logic [7:0]        run_next;

   assign can_accept = !fifo_full || (bus.rd_req && !fifo_empty);
   assign shifted    = {word_q[WORD_W-2:0], bus.raw_bit};
   assign run_next   = ((run_cnt_q != '0) && (bus.raw_bit == last_bit_q))
                       ? run_cnt_q + 8'd1 : 8'd1;

   // Next-state, word assembly, health test and push decision.
   always_comb begin
      state_d       = state_q;
      warm_cnt_d    = warm_cnt_q;
      word_d        = word_q;
      bit_cnt_d     = bit_cnt_q;
      pending_d     = pending_q;
      last_bit_d    = last_bit_q;
      run_cnt_d     = run_cnt_q;
      health_fail_d = health_fail_q;
      fifo_push     = 1'b0;
      push_word     = word_q;

      if (bus.ctrl_clear) begin
         state_d       = TRNG_IDLE;
         warm_cnt_d    = '0;
         word_d        = '0;
         bit_cnt_d     = '0;
         pending_d     = 1'b0;
         last_bit_d    = 1'b0;
         run_cnt_d     = '0;
         health_fail_d = 1'b0;
      end else begin
         case (state_q)
            TRNG_IDLE: begin
               if (bus.ctrl_enable) begin
                  state_d    = TRNG_WARMUP;
                  warm_cnt_d = '0;
               end
            end
            TRNG_WARMUP: begin
               if (!bus.ctrl_enable) begin
                  state_d    = TRNG_IDLE;
                  warm_cnt_d = '0;
               end else if (warm_cnt_q == WW'(WARMUP_CYCLES - 1)) begin
                  state_d    = TRNG_COLLECT;
                  warm_cnt_d = '0;
               end else begin
                  warm_cnt_d = warm_cnt_q + WW'(1);
               end
            end
            TRNG_COLLECT: begin
               if (!bus.ctrl_enable) begin
                  state_d    = TRNG_IDLE;
                  word_d     = '0;
                  bit_cnt_d  = '0;
                  pending_d  = 1'b0;
                  last_bit_d = 1'b0;
                  run_cnt_d  = '0;
               end else if (pending_q) begin
                  // Completed word parked in word_q; sampling stalls until a slot frees.
                  if (can_accept) begin
                     fifo_push = 1'b1;
                     push_word = word_q;
                     pending_d = 1'b0;
                     word_d    = '0;
                  end
               end else if (bus.raw_valid) begin
                  if (run_next >= 8'(RCT_CUTOFF)) begin
                     state_d       = TRNG_FAULT;
                     health_fail_d = 1'b1;
                     word_d        = '0;
                     bit_cnt_d     = '0;
                     last_bit_d    = 1'b0;
                     run_cnt_d     = '0;
                  end else begin
                     run_cnt_d  = run_next;
                     last_bit_d = bus.raw_bit;
                     if (bit_cnt_q == BW'(WORD_W - 1)) begin
                        bit_cnt_d = '0;
                        if (can_accept) begin
                           fifo_push = 1'b1;
                           push_word = shifted;
                           word_d    = '0;
                        end else begin
                           word_d    = shifted;
                           pending_d = 1'b1;
                        end
                     end else begin
                        word_d    = shifted;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                     end
                  end
               end
            end
            TRNG_FAULT: begin
               state_d = TRNG_FAULT;
            end
            default: begin
               state_d = TRNG_IDLE;
            end
         endcase
      end
   end

   // Controller state registers.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q       <= TRNG_IDLE;
         warm_cnt_q    <= '0;
         word_q        <= '0;
         bit_cnt_q     <= '0;
         pending_q     <= 1'b0;
         last_bit_q    <= 1'b0;
         run_cnt_q     <= '0;
         health_fail_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         warm_cnt_q    <= warm_cnt_d;
         word_q        <= word_d;
         bit_cnt_q     <= bit_cnt_d;
         pending_q     <= pending_d;
         last_bit_q    <= last_bit_d;
         run_cnt_q     <= run_cnt_d;
         health_fail_q <= health_fail_d;
      end
   end

   trng_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .clr       (bus.ctrl_clear),
      .push      (fifo_push),
      .push_data (push_word),
      .pop       (bus.rd_req),
      .head      (bus.rd_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (bus.fifo_count)
   );

   assign bus.data_avail  = !fifo_empty;
   assign bus.osc_en      = (state_q == TRNG_WARMUP) || (state_q == TRNG_COLLECT);
   assign bus.health_fail = health_fail_q;
   assign bus.state       = state_q;

endmodule : trng_sample_ctrl

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: directed stimulus, expected words queued at
// issue time and checked by a monitor on every read of a non-empty FIFO.
module tb_trng_sample_ctrl;

   localparam int unsigned WARM = 64;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] expq[$];

   trng_sample_ctrl_if #(.FIFO_DEPTH(4)) bus ();

   trng_sample_ctrl #(
      .WARMUP_CYCLES (WARM),
      .RCT_CUTOFF    (16),
      .FIFO_DEPTH    (4)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; pulses drop after the edge.
   task automatic tick(input logic b, input logic v, input logic rd, input logic clr);
      bus.raw_bit    = b;
      bus.raw_valid  = v;
      bus.rd_req     = rd;
      bus.ctrl_clear = clr;
      @(posedge clk);
      #1;
      bus.raw_valid  = 1'b0;
      bus.rd_req     = 1'b0;
      bus.ctrl_clear = 1'b0;
   endtask

   task automatic feed_bits(input logic [31:0] w, input int n);
      for (int i = 31; i > 31 - n; i--) tick(w[i], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic feed_word(input logic [31:0] w);
      feed_bits(w, 32);
      expq.push_back(w);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_state"},  32'(bus.state),       32'd0);
      chk({p, "_osc_en"}, 32'(bus.osc_en),      32'd0);
      chk({p, "_rdata"},  bus.rd_data,          32'd0);
      chk({p, "_avail"},  32'(bus.data_avail),  32'd0);
      chk({p, "_count"},  32'(bus.fifo_count),  32'd0);
      chk({p, "_health"}, 32'(bus.health_fail), 32'd0);
   endtask

   // Enable and walk through warm-up; raw ones fed throughout must be ignored.
   task automatic warmup(input string p);
      bus.ctrl_enable = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk({p, "_osc_on"}, 32'(bus.osc_en), 32'd1);
      chk({p, "_warmup"}, 32'(bus.state),  32'd1);
      repeat (WARM - 1) tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk({p, "_warm_last"}, 32'(bus.state), 32'd1);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk({p, "_collect"}, 32'(bus.state), 32'd2);
   endtask

   // Scoreboard monitor: every accepted read is compared with the oldest expected word.
   initial begin
      logic [31:0] w;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rd_req) begin
            if (bus.data_avail) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rd_unexpected: got 0x%08h expected no word", bus.rd_data);
               end else begin
                  w = expq.pop_front();
                  chk("rd_data", bus.rd_data, w);
               end
            end else if (expq.size() != 0) begin
               checks++;
               failures++;
               $display("FAIL rd_missing: got empty FIFO expected 0x%08h", expq[0]);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      bus.ctrl_enable = 1'b0;
      bus.ctrl_clear  = 1'b0;
      bus.raw_bit     = 1'b0;
      bus.raw_valid   = 1'b0;
      bus.rd_req      = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);

      // Alternating 1,0 word and one-cycle push latency.
      warmup("w1");
      w = 32'hAAAA_AAAA;
      feed_bits(w, 31);
      chk("avail_before_32", 32'(bus.data_avail), 32'd0);
      tick(w[0], 1'b1, 1'b0, 1'b0);
      expq.push_back(w);
      chk("avail_after_32", 32'(bus.data_avail), 32'd1);
      chk("count_one", 32'(bus.fifo_count), 32'd1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("count_after_read", 32'(bus.fifo_count), 32'd0);

      // Repetition-count trip, FIFO readable in FAULT, clear.
      feed_word(32'hDEAD_BEEF);
      feed_word(32'h1234_5678);
      repeat (15) tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rct_15_ok", 32'(bus.state), 32'd2);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rct_fault", 32'(bus.state), 32'd3);
      chk("rct_health", 32'(bus.health_fail), 32'd1);
      chk("rct_osc_off", 32'(bus.osc_en), 32'd0);
      chk("rct_count", 32'(bus.fifo_count), 32'd2);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("fault_read_count", 32'(bus.fifo_count), 32'd1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      expq.delete();
      chk("clr_state", 32'(bus.state), 32'd0);
      chk("clr_health", 32'(bus.health_fail), 32'd0);
      chk("clr_count", 32'(bus.fifo_count), 32'd0);
      chk("clr_rdata", bus.rd_data, 32'd0);
      bus.ctrl_enable = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);

      // Full FIFO: fifth word held, extra bits ignored, push in the pop cycle.
      warmup("w2");
      feed_word(32'hC3C3_C3C3);
      feed_word(32'h0F0F_0F0F);
      feed_word(32'h5555_5555);
      feed_word(32'h1234_5678);
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      feed_word(32'hDEAD_BEEF);
      chk("held_count", 32'(bus.fifo_count), 32'd4);
      repeat (20) tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk("held_ignore_state", 32'(bus.state), 32'd2);
      chk("held_ignore_health", 32'(bus.health_fail), 32'd0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("pop_push_count", 32'(bus.fifo_count), 32'd4);
      repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain_count", 32'(bus.fifo_count), 32'd0);
      chk("drain_avail", 32'(bus.data_avail), 32'd0);

      // Enable drop mid-word discards the partial word.
      feed_bits(32'h5A5A_5A5A, 20);
      bus.ctrl_enable = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk("disable_idle", 32'(bus.state), 32'd0);
      chk("disable_osc", 32'(bus.osc_en), 32'd0);
      warmup("w3");
      feed_word(32'hAAAA_AAAA);
      chk("reenable_count", 32'(bus.fifo_count), 32'd1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-word with a word buffered.
      feed_word(32'h0F0F_0F0F);
      feed_bits(32'h5555_5555, 10);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      expq.delete();
      bus.ctrl_enable = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("rd_empty_count", 32'(bus.fifo_count), 32'd0);
      chk("rd_empty_data", bus.rd_data, 32'd0);
      warmup("w4");
      feed_word(32'hAAAA_AAAA);
      tick(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset while in FAULT.
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (15) tick(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rct0_15_ok", 32'(bus.state), 32'd2);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rct0_fault", 32'(bus.state), 32'd3);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_fault");
      bus.ctrl_enable = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);

      // Clear coincident with the 32nd bit and a read.
      warmup("w5");
      feed_word(32'h5555_5555);
      w = 32'hC3C3_C3C3;
      feed_bits(w, 31);
      tick(w[0], 1'b1, 1'b1, 1'b1);
      expq.delete();
      chk("coinc_count", 32'(bus.fifo_count), 32'd0);
      chk("coinc_state", 32'(bus.state), 32'd0);
      chk("coinc_avail", 32'(bus.data_avail), 32'd0);
      bus.ctrl_enable = 1'b0;
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk("coinc_no_late_push", 32'(bus.fifo_count), 32'd0);
      chk("queue_drained", 32'(expq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_trng_sample_ctrl
